// File: rtl/wddl_pkg.sv
// Shared types and rail codes for the WDDL
// dual-rail exit decoder.
package wddl_pkg;

  typedef enum logic {
    SPACER_WAIT = 1'b0,
    EVAL_WAIT   = 1'b1
  } state_e;

  localparam logic [1:0] SPACER  = 2'b00;
  localparam logic [1:0] ILLEGAL = 2'b11;

endpackage

// File: rtl/wddl_word_classify.sv
// Per-bit dual-rail classification reduced
// to word-level completion flags.
module wddl_word_classify
  import wddl_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic [WORD-1:0] t_i,
  input  logic [WORD-1:0] f_i,
  output logic            all_spacer_o,
  output logic            all_valid_o,
  output logic            any_illegal_o,
  output logic            any_active_o
);

  logic [1:0] code;

  // Fold every rail pair into the four word flags
  always_comb begin
    all_spacer_o  = 1'b1;
    all_valid_o   = 1'b1;
    any_illegal_o = 1'b0;
    any_active_o  = 1'b0;
    code          = SPACER;
    for (int i = 0; i < WORD; i++) begin
      code = {t_i[i], f_i[i]};
      if (code != SPACER) begin
        all_spacer_o = 1'b0;
        any_active_o = 1'b1;
      end
      if (code == SPACER || code == ILLEGAL)
        all_valid_o = 1'b0;
      if (code == ILLEGAL)
        any_illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/wddl_word_decoder.sv
// WDDL dual-rail to single-rail exit decoder
// with completion FSM and one-entry buffer.
module wddl_word_decoder
  import wddl_pkg::*;
#(
  parameter int WORD    = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WORD-1:0] In_T,
  input  logic [WORD-1:0] In_F,
  output logic [WORD-1:0] Out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            err_illegal,
  output logic            err_timeout,
  output logic            err_overrun,
  input  logic            err_clr
);

  logic [WORD-1:0]  t_q, f_q;
  logic [WORD-1:0]  out_q, out_d;
  logic             vld_q, vld_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_q, err_d;
  logic             spc, vld, ill, act;
  logic             cap, to_ev, ovr_ev;

  wddl_word_classify #(
    .WORD(WORD)
  ) u_cls (
    .t_i          (t_q),
    .f_i          (f_q),
    .all_spacer_o (spc),
    .all_valid_o  (vld),
    .any_illegal_o(ill),
    .any_active_o (act)
  );

  // Completion FSM, output buffer and sticky flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    to_ev   = 1'b0;
    if (ill) begin
      state_d = SPACER_WAIT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SPACER_WAIT: begin
          if (spc) begin
            state_d = EVAL_WAIT;
            cnt_d   = '0;
          end
        end
        EVAL_WAIT: begin
          if (vld) begin
            cap     = 1'b1;
            state_d = SPACER_WAIT;
            cnt_d   = '0;
          end else if (act) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              to_ev   = 1'b1;
              state_d = SPACER_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SPACER_WAIT;
      endcase
    end
    ovr_ev = cap & vld_q & ~out_ready;
    out_d  = out_q;
    vld_d  = vld_q & ~out_ready;
    if (cap && (!vld_q || out_ready)) begin
      out_d = t_q;
      vld_d = 1'b1;
    end
    err_d = (err_q & {3{~err_clr}})
          | {ill, to_ev, ovr_ev};
  end

  // State, input samples and buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q     <= '0;
      f_q     <= '0;
      state_q <= SPACER_WAIT;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      t_q     <= In_T;
      f_q     <= In_F;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign Out         = out_q;
  assign out_valid   = vld_q;
  assign err_illegal = err_q[2];
  assign err_timeout = err_q[1];
  assign err_overrun = err_q[0];

endmodule

// File: tb/tb_wddl_word_decoder.sv
// Directed plus randomized bench for the
// WDDL exit decoder with a reference model.
module tb_wddl_word_decoder;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] In_T, In_F, Out;
  logic        out_valid, out_ready;
  logic        err_illegal, err_timeout;
  logic        err_overrun, err_clr;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] mT, mF, mOut;
  bit          mValid, mIll, mTo, mOvr;
  bit          armed;
  int          run;

  always #5 clk = ~clk;

  wddl_word_decoder #(
    .WORD(32), .TIMEOUT(TMO), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .In_T(In_T), .In_F(In_F),
    .Out(Out), .out_valid(out_valid),
    .out_ready(out_ready),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .err_clr(err_clr)
  );

  task automatic chk32(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mT = '0; mF = '0; mOut = '0;
    mValid = 0; mIll = 0; mTo = 0; mOvr = 0;
    armed = 0; run = 0;
  endtask

  // one clock of the protocol, from pin values
  task automatic model_step();
    bit spc, val, ill, act, cap, ie, te, oe;
    spc = ((mT | mF) == 32'h0);
    ill = ((mT & mF) != 32'h0);
    val = ((mT ^ mF) == 32'hFFFF_FFFF);
    act = !spc;
    cap = 0; ie = 0; te = 0; oe = 0;
    if (ill) begin
      ie = 1; armed = 0; run = 0;
    end else if (!armed) begin
      if (spc) begin armed = 1; run = 0; end
    end else if (val) begin
      cap = 1; armed = 0; run = 0;
    end else if (act) begin
      run = run + 1;
      if (run == TMO) begin
        te = 1; armed = 0; run = 0;
      end
    end else begin
      run = 0;
    end
    if (cap && (!mValid || out_ready)) begin
      mOut = mT; mValid = 1;
    end else begin
      if (cap) oe = 1;
      if (mValid && out_ready) mValid = 0;
    end
    if (err_clr) begin
      mIll = 0; mTo = 0; mOvr = 0;
    end
    mIll = mIll | ie;
    mTo  = mTo  | te;
    mOvr = mOvr | oe;
    mT = In_T; mF = In_F;
  endtask

  task automatic check_all();
    chk32("Out", Out, mOut);
    chk1("out_valid", out_valid, mValid);
    chk1("err_illegal", err_illegal, mIll);
    chk1("err_timeout", err_timeout, mTo);
    chk1("err_overrun", err_overrun, mOvr);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic step(input logic [31:0] t,
                      input logic [31:0] f,
                      input int n);
    In_T = t; In_F = f;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic word(input logic [31:0] w,
                      input int n);
    step(w, ~w, n);
  endtask

  task automatic clr_errs();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
  endtask

  initial begin
    int first;
    logic [31:0] r, m;
    int kind, b;
    rst_n = 1'b0;
    In_T = '0; In_F = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    #1;
    check_all();
    #11 rst_n = 1'b1;

    // basic decode
    out_ready = 1'b1;
    step(0, 0, 2);
    word(32'hA5A5_5A5A, 1);
    chk1("lat_n1", out_valid, 1'b0);
    word(32'hA5A5_5A5A, 1);
    chk1("lat_n2", out_valid, 1'b1);
    chk32("basic_out", Out, 32'hA5A5_5A5A);
    word(32'hA5A5_5A5A, 1);
    chk1("single_pulse", out_valid, 1'b0);
    step(0, 0, 2);

    // backpressure and overrun
    out_ready = 1'b0;
    word(32'h1, 2);
    step(0, 0, 2);
    word(32'h2, 2);
    step(0, 0, 2);
    chk32("bp_out", Out, 32'h1);
    chk1("bp_ovr", err_overrun, 1'b1);
    out_ready = 1'b1;
    cyc();
    chk1("bp_drain", out_valid, 1'b0);
    clr_errs();

    // illegal code on bit 7
    step(0, 0, 2);
    r = 32'h0F0F_0F0F;
    step(r | 32'h80, ~r | 32'h80, 2);
    chk1("ill_flag", err_illegal, 1'b1);
    chk1("ill_nocap", out_valid, 1'b0);
    step(0, 0, 2);
    word(32'hFFFF_0000, 2);
    chk32("ill_after", Out, 32'hFFFF_0000);
    step(0, 0, 1);
    clr_errs();
    chk1("ill_clr", err_illegal, 1'b0);

    // timeout on half-evaluated word
    step(0, 0, 2);
    In_T = 32'h0000_1234;
    In_F = 32'h0000_EDCB;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (err_timeout && first == 0) first = i;
    end
    chk32("to_cycle", first, TMO + 1);
    word(32'hCAFE_F00D, 3);
    chk1("to_stale", out_valid, 1'b0);
    step(0, 0, 2);
    clr_errs();

    // back-to-back codewords without spacer
    word(32'h1234_5678, 2);
    word(32'h8765_4321, 2);
    step(0, 0, 2);
    chk32("b2b_out", Out, 32'h1234_5678);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      kind = $urandom_range(0, 9);
      r = $urandom;
      if (kind < 4) begin
        In_T = '0; In_F = '0;
      end else if (kind < 8) begin
        In_T = r; In_F = ~r;
      end else if (kind == 8) begin
        m = $urandom;
        In_T = r & m; In_F = ~r & m;
      end else begin
        b = $urandom_range(0, 31);
        In_T = r | (32'h1 << b);
        In_F = ~r | (32'h1 << b);
      end
      for (int k = $urandom_range(1, 3); k > 0; k--)
        cyc();
    end
    err_clr = 1'b0;

    // async reset while a word is held
    out_ready = 1'b0;
    step(0, 0, 2);
    word(32'h5555_AAAA, 2);
    chk1("hold_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk1("arst_valid", out_valid, 1'b0);
    chk32("arst_out", Out, 32'h0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step(0, 0, 2);
    word(32'h0BAD_BEEF, 3);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
